fcs_gen: RTL and testbench

FCS_GEN -- requirements
Module: fcs_gen

---
 rtl/fcs_gen.sv | 166 ++++++++++++++++
 tb/tb_fcs_gen.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcs_gen.sv
// Ethernet FCS generator: streams frames from a FWFT byte FIFO and appends a CRC-32 FCS.
// Define FCS_GEN_PAD_EN to zero-pad short frames up to P_MIN_LEN bytes before the FCS.
module fcs_gen #(
  parameter int unsigned P_IFG     = 12,
  parameter int unsigned P_MIN_LEN = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  input  logic       fifo_last,
  output logic       fifo_rd_en,
  output logic       tx_ctrl,
  output logic [7:0] tx_data,
  output logic       tx_done,
  output logic       tx_underrun
);

`ifdef FCS_GEN_PAD_EN
  localparam bit PadEn = 1'b1;
`else
  localparam bit PadEn = 1'b0;
`endif

  localparam logic [10:0] MinLen  = 11'(P_MIN_LEN);
  localparam logic [10:0] CntMax  = 11'h7FF;
  localparam logic [15:0] IfgLast = 16'(P_IFG - 1);

  typedef enum logic [2:0] {StIdle, StData, StPad, StFcs, StDrop, StIfg} state_e;

  state_e      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [10:0] cnt_q, cnt_d;
  logic [1:0]  fcs_idx_q, fcs_idx_d;
  logic [15:0] ifg_q, ifg_d;
  logic        done_pend_q, done_pend_d;
  logic        tx_ctrl_q, tx_ctrl_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_done_q;
  logic        tx_underrun_q, tx_underrun_d;

  logic [31:0] crc_base;
  logic [10:0] cnt_base, cnt_inc;
  logic        pad_needed;

  // Reflected CRC-32 update, LSB of the byte first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // A pop in IDLE starts a new frame, so CRC and count restart from their presets there.
  assign crc_base   = (state_q == StIdle) ? 32'hFFFF_FFFF : crc_q;
  assign cnt_base   = (state_q == StIdle) ? 11'd0 : cnt_q;
  assign cnt_inc    = (cnt_base == CntMax) ? cnt_base : cnt_base + 11'd1;
  assign pad_needed = PadEn && (cnt_inc < MinLen);

  always_comb begin
    state_d       = state_q;
    crc_d         = crc_q;
    cnt_d         = cnt_q;
    fcs_idx_d     = fcs_idx_q;
    ifg_d         = ifg_q;
    done_pend_d   = 1'b0;
    tx_ctrl_d     = 1'b0;
    tx_data_d     = 8'h00;
    tx_underrun_d = 1'b0;
    fifo_rd_en    = 1'b0;

    unique case (state_q)
      StIdle, StData: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          tx_ctrl_d  = 1'b1;
          tx_data_d  = fifo_data;
          crc_d      = crc_byte(crc_base, fifo_data);
          cnt_d      = cnt_inc;
          fcs_idx_d  = 2'd0;
          if (fifo_last) begin
            state_d = pad_needed ? StPad : StFcs;
          end else begin
            state_d = StData;
          end
        end else if (state_q == StData) begin
          tx_underrun_d = 1'b1;
          state_d       = StDrop;
        end
      end
      StPad: begin
        tx_ctrl_d = 1'b1;
        crc_d     = crc_byte(crc_q, 8'h00);
        cnt_d     = cnt_inc;
        if (cnt_inc >= MinLen) begin
          state_d = StFcs;
        end
      end
      StFcs: begin
        tx_ctrl_d = 1'b1;
        tx_data_d = ~crc_q[8*fcs_idx_q +: 8];
        fcs_idx_d = fcs_idx_q + 2'd1;
        if (fcs_idx_q == 2'd3) begin
          state_d     = StIfg;
          ifg_d       = 16'd0;
          done_pend_d = 1'b1;
        end
      end
      StDrop: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          if (fifo_last) begin
            state_d = StIfg;
            ifg_d   = 16'd0;
          end
        end
      end
      StIfg: begin
        ifg_d = ifg_q + 16'd1;
        if (ifg_q == IfgLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (reset) begin
      fifo_rd_en = 1'b0;
    end
  end

  // done_pend delays tx_done so it lands on the first idle output cycle after the last FCS byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      crc_q         <= 32'hFFFF_FFFF;
      cnt_q         <= 11'd0;
      fcs_idx_q     <= 2'd0;
      ifg_q         <= 16'd0;
      done_pend_q   <= 1'b0;
      tx_ctrl_q     <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_done_q     <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      crc_q         <= crc_d;
      cnt_q         <= cnt_d;
      fcs_idx_q     <= fcs_idx_d;
      ifg_q         <= ifg_d;
      done_pend_q   <= done_pend_d;
      tx_ctrl_q     <= tx_ctrl_d;
      tx_data_q     <= tx_data_d;
      tx_done_q     <= done_pend_q;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign tx_ctrl     = tx_ctrl_q;
  assign tx_data     = tx_data_q;
  assign tx_done     = tx_done_q;
  assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_fcs_gen.sv
// Directed self-checking bench for fcs_gen with a first-word fall-through FIFO model.
// Expectations follow FCS_GEN_PAD_EN when the bench is built with it.
module tb_fcs_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_last = 1'b0;
  logic       fifo_rd_en;
  logic       tx_ctrl;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       tx_underrun;

  int nvec = 0;
  int nfail = 0;

  fcs_gen dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_last  (fifo_last),
    .fifo_rd_en (fifo_rd_en),
    .tx_ctrl    (tx_ctrl),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

`ifdef FCS_GEN_PAD_EN
  localparam int LEN9 = 64;
  localparam int LEN1 = 64;
`else
  localparam int LEN9 = 13;
  localparam int LEN1 = 5;
  logic [7:0] tab9 [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                            8'h26, 8'h39, 8'hF4, 8'hCB};
  logic [7:0] tab1 [5]  = '{8'h00, 8'h8D, 8'hEF, 8'h02, 8'hD2};
`endif

  // FIFO contents: {last, data}
  logic [8:0] q[$];
  bit         pend = 1'b0;
  logic [7:0] fb [128];

  // Pops what the DUT took at the preceding posedge, then presents the new head.
  initial begin : fifo_model
    forever begin
      @(negedge clk);
      if (pend && q.size() > 0) q.delete(0);
      pend = 1'b0;
      if (q.size() > 0) begin
        fifo_empty = 1'b0;
        fifo_data  = q[0][7:0];
        fifo_last  = q[0][8];
      end else begin
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;
        fifo_last  = 1'b0;
      end
      #1 pend = fifo_rd_en;
    end
  end

  int         cyc, first_rd, viol_data, viol_rd;
  logic [7:0] ob[$];
  int         cc[$], dc[$], uc[$];

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Running CRC over a frame including its FCS; a good frame leaves 0xDEBB20E3.
  function automatic logic [31:0] residue(input int s, input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int j = 0; j < n; j++) c = crc_byte(c, ob[s+j]);
    return c;
  endfunction

  function automatic logic [7:0] exp_frame9(input int i);
`ifdef FCS_GEN_PAD_EN
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int j = 0; j < 60; j++) c = crc_byte(c, (j < 9) ? 8'(8'h31 + j) : 8'h00);
    if (i < 9) return 8'(8'h31 + i);
    if (i < 60) return 8'h00;
    return ~c[8*(i-60) +: 8];
`else
    return tab9[i];
`endif
  endfunction

  function automatic logic [7:0] exp_frame1(input int i);
`ifdef FCS_GEN_PAD_EN
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int j = 0; j < 60; j++) c = crc_byte(c, 8'h00);
    if (i < 60) return 8'h00;
    return ~c[8*(i-60) +: 8];
`else
    return tab1[i];
`endif
  endfunction

  task automatic clear_cap();
    cyc = 0;
    first_rd = -1;
    ob.delete();
    cc.delete();
    dc.delete();
    uc.delete();
  endtask

  task automatic capture(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
      if (tx_ctrl) begin
        ob.push_back(tx_data);
        cc.push_back(cyc);
      end else if (tx_data !== 8'h00) begin
        viol_data++;
      end
      if (tx_done) dc.push_back(cyc);
      if (tx_underrun) uc.push_back(cyc);
      if (fifo_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        if (fifo_empty) viol_rd++;
      end
      cyc++;
    end
  endtask

  task automatic push_bytes(input int s, input int n, input bit mark_last);
    for (int i = 0; i < n; i++) q.push_back({mark_last && (i == n - 1), fb[s+i]});
  endtask

  task automatic fill9();
    for (int i = 0; i < 9; i++) fb[i] = 8'(8'h31 + i);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    q.push_back({1'b1, 8'hAA});
    clear_cap();
    capture(3);
    nvec++; if (fifo_rd_en !== 1'b0) begin nfail++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en); end
    nvec++; if (tx_ctrl !== 1'b0) begin nfail++; $display("FAIL rst_ctrl: got %b want 0", tx_ctrl); end
    nvec++; if (tx_data !== 8'h00) begin nfail++; $display("FAIL rst_data: got %h want 00", tx_data); end
    nvec++; if (tx_done !== 1'b0) begin nfail++; $display("FAIL rst_done: got %b want 0", tx_done); end
    nvec++; if (tx_underrun !== 1'b0) begin nfail++; $display("FAIL rst_underrun: got %b want 0", tx_underrun); end
    q.delete();
    capture(2);
    reset = 1'b0;
    capture(4);
  endtask

  task automatic test_check_value();
    fill9();
    clear_cap();
    push_bytes(0, 9, 1'b1);
    capture(100);
    nvec++; if (ob.size() !== LEN9) begin nfail++; $display("FAIL cv_len: got %0d want %0d", ob.size(), LEN9); end
    for (int i = 0; i < LEN9; i++) begin
      nvec++;
      if (ob[i] !== exp_frame9(i)) begin
        nfail++; $display("FAIL cv_byte%0d: got %h want %h", i, ob[i], exp_frame9(i));
      end
    end
    nvec++; if (residue(0, LEN9) !== 32'hDEBB20E3) begin nfail++; $display("FAIL cv_residue: got %h want debb20e3", residue(0, LEN9)); end
    nvec++; if (cc[LEN9-1] - cc[0] + 1 !== LEN9) begin nfail++; $display("FAIL cv_contig: got %0d want %0d", cc[LEN9-1] - cc[0] + 1, LEN9); end
    nvec++; if (cc[0] !== first_rd + 1) begin nfail++; $display("FAIL cv_latency: got %0d want %0d", cc[0], first_rd + 1); end
    nvec++; if (dc.size() !== 1) begin nfail++; $display("FAIL cv_done_cnt: got %0d want 1", dc.size()); end
    nvec++; if (dc[0] !== cc[LEN9-1] + 1) begin nfail++; $display("FAIL cv_done_cyc: got %0d want %0d", dc[0], cc[LEN9-1] + 1); end
    nvec++; if (uc.size() !== 0) begin nfail++; $display("FAIL cv_underrun: got %0d want 0", uc.size()); end
  endtask

  task automatic test_one_byte();
    fb[0] = 8'h00;
    clear_cap();
    push_bytes(0, 1, 1'b1);
    capture(100);
    nvec++; if (ob.size() !== LEN1) begin nfail++; $display("FAIL ob_len: got %0d want %0d", ob.size(), LEN1); end
    for (int i = 0; i < LEN1; i++) begin
      nvec++;
      if (ob[i] !== exp_frame1(i)) begin
        nfail++; $display("FAIL ob_byte%0d: got %h want %h", i, ob[i], exp_frame1(i));
      end
    end
    nvec++; if (dc.size() !== 1) begin nfail++; $display("FAIL ob_done_cnt: got %0d want 1", dc.size()); end
    nvec++; if (dc[0] !== cc[LEN1-1] + 1) begin nfail++; $display("FAIL ob_done_cyc: got %0d want %0d", dc[0], cc[LEN1-1] + 1); end
  endtask

  task automatic test_back_to_back();
    fill9();
    clear_cap();
    push_bytes(0, 9, 1'b1);
    fb[0] = 8'h00;
    push_bytes(0, 1, 1'b1);
    capture(220);
    nvec++; if (ob.size() !== LEN9 + LEN1) begin nfail++; $display("FAIL b2b_len: got %0d want %0d", ob.size(), LEN9 + LEN1); end
    for (int i = 0; i < LEN9; i++) begin
      nvec++;
      if (ob[i] !== exp_frame9(i)) begin
        nfail++; $display("FAIL b2b_f1_byte%0d: got %h want %h", i, ob[i], exp_frame9(i));
      end
    end
    for (int i = 0; i < LEN1; i++) begin
      nvec++;
      if (ob[LEN9+i] !== exp_frame1(i)) begin
        nfail++; $display("FAIL b2b_f2_byte%0d: got %h want %h", i, ob[LEN9+i], exp_frame1(i));
      end
    end
    nvec++; if (cc[LEN9] - cc[LEN9-1] - 1 !== 12) begin nfail++; $display("FAIL b2b_ifg: got %0d want 12", cc[LEN9] - cc[LEN9-1] - 1); end
    nvec++; if (dc.size() !== 2) begin nfail++; $display("FAIL b2b_done_cnt: got %0d want 2", dc.size()); end
    nvec++; if (dc[0] !== cc[LEN9-1] + 1) begin nfail++; $display("FAIL b2b_done_cyc: got %0d want %0d", dc[0], cc[LEN9-1] + 1); end
  endtask

  task automatic test_underrun();
    for (int i = 0; i < 20; i++) fb[i] = 8'(8'h40 + i);
    clear_cap();
    push_bytes(0, 5, 1'b0);
    capture(20);
    nvec++; if (ob.size() !== 5) begin nfail++; $display("FAIL ur_len: got %0d want 5", ob.size()); end
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if (ob[i] !== 8'(8'h40 + i)) begin
        nfail++; $display("FAIL ur_byte%0d: got %h want %h", i, ob[i], 8'(8'h40 + i));
      end
    end
    nvec++; if (uc.size() !== 1) begin nfail++; $display("FAIL ur_pulse_cnt: got %0d want 1", uc.size()); end
    nvec++; if (uc[0] !== cc[4] + 1) begin nfail++; $display("FAIL ur_pulse_cyc: got %0d want %0d", uc[0], cc[4] + 1); end
    push_bytes(5, 15, 1'b1);
    capture(40);
    nvec++; if (q.size() !== 0) begin nfail++; $display("FAIL ur_drained: got %0d left want 0", q.size()); end
    nvec++; if (cc.size() !== 5) begin nfail++; $display("FAIL ur_ctrl_quiet: got %0d want 5", cc.size()); end
    nvec++; if (dc.size() !== 0) begin nfail++; $display("FAIL ur_no_done: got %0d want 0", dc.size()); end
    nvec++; if (uc.size() !== 1) begin nfail++; $display("FAIL ur_single: got %0d want 1", uc.size()); end
    fill9();
    clear_cap();
    push_bytes(0, 9, 1'b1);
    capture(100);
    nvec++; if (ob.size() !== LEN9) begin nfail++; $display("FAIL ur_next_len: got %0d want %0d", ob.size(), LEN9); end
    for (int i = 0; i < LEN9; i++) begin
      nvec++;
      if (ob[i] !== exp_frame9(i)) begin
        nfail++; $display("FAIL ur_next_byte%0d: got %h want %h", i, ob[i], exp_frame9(i));
      end
    end
    nvec++; if (dc.size() !== 1) begin nfail++; $display("FAIL ur_next_done: got %0d want 1", dc.size()); end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 100; i++) fb[i] = 8'(i * 3 + 1);
    clear_cap();
    push_bytes(0, 100, 1'b1);
    for (int k = 0; k < 200 && cc.size() < 30; k++) capture(1);
    nvec++; if (cc.size() !== 30) begin nfail++; $display("FAIL rm_reach30: got %0d want 30", cc.size()); end
    reset = 1'b1;
    capture(1);
    nvec++; if (tx_ctrl !== 1'b0) begin nfail++; $display("FAIL rm_ctrl: got %b want 0", tx_ctrl); end
    nvec++; if (tx_data !== 8'h00) begin nfail++; $display("FAIL rm_data: got %h want 00", tx_data); end
    nvec++; if (fifo_rd_en !== 1'b0) begin nfail++; $display("FAIL rm_rd_en: got %b want 0", fifo_rd_en); end
    q.delete();
    capture(2);
    reset = 1'b0;
    capture(20);
    nvec++; if (cc.size() !== 30) begin nfail++; $display("FAIL rm_no_more: got %0d want 30", cc.size()); end
    nvec++; if (dc.size() + uc.size() !== 0) begin nfail++; $display("FAIL rm_no_pulse: got %0d want 0", dc.size() + uc.size()); end
    fill9();
    clear_cap();
    push_bytes(0, 9, 1'b1);
    capture(100);
    nvec++; if (ob.size() !== LEN9) begin nfail++; $display("FAIL rm_next_len: got %0d want %0d", ob.size(), LEN9); end
    for (int i = 0; i < LEN9; i++) begin
      nvec++;
      if (ob[i] !== exp_frame9(i)) begin
        nfail++; $display("FAIL rm_next_byte%0d: got %h want %h", i, ob[i], exp_frame9(i));
      end
    end
  endtask

  task automatic test_long_frame();
    int bad;
    for (int i = 0; i < 64; i++) fb[i] = 8'(i);
    clear_cap();
    push_bytes(0, 64, 1'b1);
    capture(150);
    bad = 0;
    for (int i = 0; i < 64; i++) if (ob[i] !== fb[i]) bad++;
    nvec++; if (ob.size() !== 68) begin nfail++; $display("FAIL lf_len: got %0d want 68", ob.size()); end
    nvec++; if (bad !== 0) begin nfail++; $display("FAIL lf_payload: got %0d bad bytes want 0", bad); end
    nvec++; if (residue(0, 68) !== 32'hDEBB20E3) begin nfail++; $display("FAIL lf_residue: got %h want debb20e3", residue(0, 68)); end
    nvec++; if (dc.size() !== 1) begin nfail++; $display("FAIL lf_done: got %0d want 1", dc.size()); end
  endtask

  initial begin
    viol_data = 0;
    viol_rd = 0;
    test_reset();
    test_check_value();
    test_one_byte();
    test_back_to_back();
    test_underrun();
    test_reset_midframe();
    test_long_frame();
    nvec++; if (viol_data !== 0) begin nfail++; $display("FAIL idle_data_zero: got %0d cycles want 0", viol_data); end
    nvec++; if (viol_rd !== 0) begin nfail++; $display("FAIL rd_while_empty: got %0d cycles want 0", viol_rd); end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
